pipe_hazard_ctl: RTL and testbench

Pipeline control unit for the five-stage Y86-64 pipeline. It sits beside Fetch, Decode, Execute, Memory and Writeback, and drives the stall and bubble inputs of the stage pipeline registers:
- detects load/use hazards on the Decode source registers;
- squashes mispredicted conditional jumps;
- drains the pipeline after `ret`;
- freezes the machine on an exceptional status.

Multi-cycle behaviour (`ret` drain, halt) is held in a small state machine. The outputs are Mealy-style decodes, valid in the same cycle.

---
 rtl/pipe_hazard_ctl.sv | 144 ++++++++++++++
 tb/tb_pipe_hazard_ctl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctl.sv
// Y86-64 pipeline control: load/use stall, mispredict squash, ret drain and
// exception freeze. Outputs are Mealy decodes of the current state and inputs.
module pipe_hazard_ctl #(
  parameter int         RET_BUBBLES = 3,
  parameter logic [3:0] REG_NONE    = 4'd15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] D_Ins_Code,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_Ins_Code,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [2:0] m_stat,
  input  logic [2:0] W_stat,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble,
  output logic       M_bubble,
  output logic       W_stall,
  output logic       halted,
  output logic [1:0] ctl_state,
  output logic [2:0] ret_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2,
    ST_ILL   = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;

  logic load_use, mispred, ret_d, exc_m, exc_w;

  function automatic logic is_exc(input logic [2:0] s);
    return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
  endfunction

  assign load_use = ((E_Ins_Code == 4'd5) || (E_Ins_Code == 4'd11)) &&
                    (E_dstM != REG_NONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign mispred  = (E_Ins_Code == 4'd7) && !e_Cnd;
  assign ret_d    = (D_Ins_Code == 4'd9);
  assign exc_m    = is_exc(m_stat);
  assign exc_w    = is_exc(W_stat);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RUN: begin
        if (exc_w) begin
          state_nxt = ST_HALT;
          cnt_nxt   = 3'd0;
        end else if (!mispred && !load_use && ret_d) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = 3'(RET_BUBBLES - 1);
        end
      end
      ST_DRAIN: begin
        if (exc_w) begin
          state_nxt = ST_HALT;
          cnt_nxt   = 3'd0;
        end else if (cnt <= 3'd1) begin
          state_nxt = ST_RUN;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      default: begin
        state_nxt = ST_HALT;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Reset gates every stall/bubble so downstream registers never see a stray hold.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    if (reset_n) begin
      case (state)
        ST_RUN: begin
          M_bubble = exc_m || exc_w;
          W_stall  = exc_w;
          if (exc_w) begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
          end else if (mispred) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
          end else if (load_use) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_bubble = 1'b1;
          end else if (ret_d) begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
          end
        end
        ST_DRAIN: begin
          F_stall  = 1'b1;
          D_bubble = 1'b1;
          E_bubble = exc_w;
          M_bubble = exc_m || exc_w;
          W_stall  = exc_w;
        end
        default: begin
          F_stall  = 1'b1;
          D_bubble = 1'b1;
          E_bubble = 1'b1;
          M_bubble = 1'b1;
          W_stall  = 1'b1;
        end
      endcase
    end
  end

  assign halted    = state[1];
  assign ctl_state = state;
  assign ret_cnt   = cnt;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl: single-cycle vector table plus
// hand-written multi-cycle sequences (ret drain, halt, reset).
module tb_pipe_hazard_ctl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] D_Ins_Code, d_srcA, d_srcB, E_Ins_Code, E_dstM;
  logic       e_Cnd;
  logic [2:0] m_stat, W_stat;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
  logic [1:0] ctl_state;
  logic [2:0] ret_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctl dut (
    .clk(clk), .reset_n(reset_n),
    .D_Ins_Code(D_Ins_Code), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_Ins_Code(E_Ins_Code), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .halted(halted), .ctl_state(ctl_state), .ret_cnt(ret_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs packed as {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_LU   = 6'b110100;
  localparam logic [5:0] O_MP   = 6'b001100;
  localparam logic [5:0] O_RET  = 6'b101000;
  localparam logic [5:0] O_MB   = 6'b000010;
  localparam logic [5:0] O_HALT = 6'b101111;

  typedef struct {
    string      name;
    logic [3:0] d_ins, srca, srcb, e_ins, dstm;
    logic       cnd;
    logic [2:0] ms, ws;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [5:0] outs();
    return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input logic [3:0] d, input logic [3:0] sa, input logic [3:0] sb,
                       input logic [3:0] e, input logic [3:0] dm, input logic c,
                       input logic [2:0] ms, input logic [2:0] ws);
    D_Ins_Code = d; d_srcA = sa; d_srcB = sb; E_Ins_Code = e; E_dstM = dm;
    e_Cnd = c; m_stat = ms; W_stat = ws;
  endtask

  task automatic idle_in();
    drive(4'd1, 4'd15, 4'd15, 4'd1, 4'd15, 1'b0, 3'd1, 3'd1);
  endtask

  // Called one time unit after a rising edge: check comb outputs mid-cycle,
  // then step through the next edge and check the registered state.
  task automatic cyc(input string name, input logic [5:0] exp_o,
                     input int exp_st, input int exp_cnt);
    #2;
    chk({name, " outs"}, int'(outs()), int'(exp_o));
    @(posedge clk); #1;
    chk({name, " state"}, int'(ctl_state), exp_st);
    chk({name, " ret_cnt"}, int'(ret_cnt), exp_cnt);
    chk({name, " halted"}, int'(halted), (exp_st == 2) ? 1 : 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    chk("reset outs", int'(outs()), 0);
    chk("reset state", int'(ctl_state), 0);
    chk("reset ret_cnt", int'(ret_cnt), 0);
    chk("reset halted", int'(halted), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_in();
  endtask

  initial begin
    vecs[0]  = '{"idle",          4'd1, 4'd15, 4'd15, 4'd1,  4'd15, 1'b0, 3'd1, 3'd1, O_NONE};
    vecs[1]  = '{"lu mrmovq srcA", 4'd6, 4'd3,  4'd15, 4'd5,  4'd3,  1'b0, 3'd1, 3'd1, O_LU};
    vecs[2]  = '{"lu popq srcB",  4'd6, 4'd0,  4'd4,  4'd11, 4'd4,  1'b0, 3'd1, 3'd1, O_LU};
    vecs[3]  = '{"lu none dst",   4'd6, 4'd15, 4'd15, 4'd5,  4'd15, 1'b0, 3'd1, 3'd1, O_NONE};
    vecs[4]  = '{"lu no match",   4'd6, 4'd2,  4'd6,  4'd5,  4'd3,  1'b0, 3'd1, 3'd1, O_NONE};
    vecs[5]  = '{"lu non-load",   4'd6, 4'd3,  4'd15, 4'd6,  4'd3,  1'b0, 3'd1, 3'd1, O_NONE};
    vecs[6]  = '{"mispred",       4'd6, 4'd15, 4'd15, 4'd7,  4'd15, 1'b0, 3'd1, 3'd1, O_MP};
    vecs[7]  = '{"mispred ret",   4'd9, 4'd15, 4'd15, 4'd7,  4'd15, 1'b0, 3'd1, 3'd1, O_MP};
    vecs[8]  = '{"jxx taken",     4'd6, 4'd15, 4'd15, 4'd7,  4'd15, 1'b1, 3'd1, 3'd1, O_NONE};
    vecs[9]  = '{"m_stat ADR",    4'd6, 4'd15, 4'd15, 4'd1,  4'd15, 1'b0, 3'd3, 3'd1, O_MB};
    vecs[10] = '{"m_stat HLT lu", 4'd6, 4'd3,  4'd15, 4'd5,  4'd3,  1'b0, 3'd2, 3'd1, O_LU | O_MB};
    vecs[11] = '{"m_stat 5 ok",   4'd6, 4'd15, 4'd15, 4'd1,  4'd15, 1'b0, 3'd5, 3'd0, O_NONE};

    idle_in();
    reset_n = 1'b1;
    #1;
    // Reset forces outputs low even under an exceptional W_stat.
    drive(4'd9, 4'd3, 4'd3, 4'd5, 4'd3, 1'b0, 3'd3, 3'd3);
    do_reset();
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].d_ins, vecs[i].srca, vecs[i].srcb, vecs[i].e_ins, vecs[i].dstm,
            vecs[i].cnd, vecs[i].ms, vecs[i].ws);
      cyc(vecs[i].name, vecs[i].exp, 0, 0);
    end

    // ret drain: exactly three F_stall cycles
    drive(4'd9, 4'd15, 4'd15, 4'd1, 4'd15, 1'b0, 3'd1, 3'd1);
    cyc("ret c0", O_RET, 1, 2);
    idle_in();
    cyc("ret c1", O_RET, 1, 1);
    cyc("ret c2", O_RET, 0, 0);
    cyc("ret done", O_NONE, 0, 0);

    // taken jump with ret in Decode follows the ret path
    drive(4'd9, 4'd15, 4'd15, 4'd7, 4'd15, 1'b1, 3'd1, 3'd1);
    cyc("jxx ret c0", O_RET, 1, 2);
    idle_in();
    cyc("jxx ret c1", O_RET, 1, 1);
    cyc("jxx ret c2", O_RET, 0, 0);

    // load/use beats ret, then ret proceeds
    drive(4'd9, 4'd15, 4'd4, 4'd11, 4'd4, 1'b0, 3'd1, 3'd1);
    cyc("lu>ret stall", O_LU, 0, 0);
    drive(4'd9, 4'd15, 4'd4, 4'd1, 4'd15, 1'b0, 3'd1, 3'd1);
    cyc("lu>ret c0", O_RET, 1, 2);
    idle_in();
    cyc("lu>ret c1", O_RET, 1, 1);
    cyc("lu>ret c2", O_RET, 0, 0);
    cyc("lu>ret done", O_NONE, 0, 0);

    // reset while draining with ret_cnt = 1
    drive(4'd9, 4'd15, 4'd15, 4'd1, 4'd15, 1'b0, 3'd1, 3'd1);
    cyc("rst drain c0", O_RET, 1, 2);
    idle_in();
    cyc("rst drain c1", O_RET, 1, 1);
    do_reset();
    cyc("after rst", O_NONE, 0, 0);

    // exception during drain goes straight to HALT
    drive(4'd9, 4'd15, 4'd15, 4'd1, 4'd15, 1'b0, 3'd1, 3'd1);
    cyc("drain exc c0", O_RET, 1, 2);
    drive(4'd1, 4'd15, 4'd15, 4'd1, 4'd15, 1'b0, 3'd1, 3'd4);
    cyc("drain exc", O_HALT, 2, 0);
    do_reset();

    // exception in Memory, then Writeback, then absorbing HALT
    drive(4'd1, 4'd15, 4'd15, 4'd1, 4'd15, 1'b0, 3'd3, 3'd1);
    cyc("exc m", O_MB, 0, 0);
    drive(4'd1, 4'd15, 4'd15, 4'd1, 4'd15, 1'b0, 3'd1, 3'd3);
    cyc("exc w", O_HALT, 2, 0);
    idle_in();
    cyc("halt hold", O_HALT, 2, 0);
    drive(4'd9, 4'd3, 4'd15, 4'd5, 4'd3, 1'b0, 3'd1, 3'd1);
    cyc("halt lu ret", O_HALT, 2, 0);
    do_reset();
    cyc("post halt", O_NONE, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

endmodule
